// File: rtl/cs_frame_sequencer_pkg.sv
// Shared types and constants for the compressive-sensing SPI datapath:
// sequencer states, error flag bit positions and default frame geometry.
package cs_pkg;

  localparam int CS_N_IN  = 64;
  localparam int CS_M_OUT = 16;

  localparam int ERR_W       = 3;
  localparam int ERR_SHORT   = 0;
  localparam int ERR_OVERRUN = 1;
  localparam int ERR_TIMEOUT = 2;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    START,
    COMPUTE,
    FETCH,
    SEND,
    DONE
  } cs_seq_state_t;

endpackage

// File: rtl/cs_frame_sequencer_timeout.sv
// Loadable down-counter guarding the COMPUTE phase; expire is high once an
// armed count has run down to zero, until clr disarms it.
module cs_seq_timeout #(
  parameter int LOAD_VAL = 4095,
  parameter int CW       = (LOAD_VAL > 1) ? $clog2(LOAD_VAL + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (clr) begin
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (load) begin
      cnt_d   = CW'(LOAD_VAL);
      armed_d = 1'b1;
    end else if (en && armed_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign expire = armed_q && (cnt_q == '0);

endmodule

// File: rtl/cs_frame_sequencer.sv
// Frame sequencer: capture N_IN sample bytes, run the engine, stream M_OUT results.
// Optional CS_SEQ_HDR_EN prefixes the results with a {frame_cnt, err_flags} header byte.
module cs_frame_sequencer
  import cs_pkg::*;
#(
  parameter int N_IN        = CS_N_IN,
  parameter int M_OUT       = CS_M_OUT,
  parameter int TIMEOUT_CYC = 4096,
  parameter int IAW         = $clog2(N_IN),
  parameter int OAW         = $clog2(M_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ssel_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             buf_wr_en,
  output logic [IAW-1:0]   buf_wr_addr,
  output logic [7:0]       buf_wr_data,
  output logic             eng_start,
  input  logic             eng_done,
  output logic [OAW-1:0]   res_rd_addr,
  input  logic [7:0]       res_rd_data,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_sent,
  output logic             frame_done,
  output logic             busy,
  output logic [ERR_W-1:0] err_flags,
  input  logic             err_clr
);

  localparam logic [IAW-1:0] IN_LAST  = IAW'(N_IN - 1);
  localparam logic [OAW-1:0] OUT_LAST = OAW'(M_OUT - 1);

  cs_seq_state_t    state_q, state_d;
  logic [IAW-1:0]   in_cnt_q, in_cnt_d;
  logic [OAW-1:0]   out_cnt_q, out_cnt_d;
  logic             fetch_wait_q, fetch_wait_d;
  logic             buf_wr_en_q, buf_wr_en_d;
  logic [IAW-1:0]   buf_wr_addr_q, buf_wr_addr_d;
  byte_t            buf_wr_data_q, buf_wr_data_d;
  logic             tx_valid_q, tx_valid_d;
  byte_t            tx_data_q, tx_data_d;
  logic [ERR_W-1:0] err_q, err_d, err_set;
  logic             tmo_load, tmo_clr, tmo_en, tmo_expire;
`ifdef CS_SEQ_HDR_EN
  logic [4:0]       frame_cnt_q, frame_cnt_d;
  logic             hdr_q, hdr_d;
`endif

  cs_seq_timeout #(
    .LOAD_VAL (TIMEOUT_CYC - 1)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmo_load),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d       = state_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    fetch_wait_d  = 1'b0;
    buf_wr_en_d   = 1'b0;
    buf_wr_addr_d = buf_wr_addr_q;
    buf_wr_data_d = buf_wr_data_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    err_set       = '0;
    tmo_load      = 1'b0;
    tmo_clr       = 1'b0;
    tmo_en        = 1'b0;
`ifdef CS_SEQ_HDR_EN
    frame_cnt_d   = frame_cnt_q;
    hdr_d         = hdr_q;
`endif

    case (state_q)
      IDLE: begin
        if (!ssel_n) begin
          state_d  = RECV;
          in_cnt_d = '0;
        end
      end
      RECV: begin
        if (rx_valid) begin
          buf_wr_en_d   = 1'b1;
          buf_wr_addr_d = in_cnt_q;
          buf_wr_data_d = rx_data;
          if (in_cnt_q == IN_LAST) state_d = START;
          else                     in_cnt_d = in_cnt_q + IAW'(1);
        end
        // A final byte arriving with the deselect still completes the frame.
        if (ssel_n && (state_d != START)) begin
          err_set[ERR_SHORT] = 1'b1;
          state_d            = IDLE;
        end
      end
      START: begin
        tmo_load = 1'b1;
        state_d  = COMPUTE;
      end
      COMPUTE: begin
        tmo_en = 1'b1;
        if (eng_done) begin
          tmo_clr   = 1'b1;
          out_cnt_d = '0;
`ifdef CS_SEQ_HDR_EN
          tx_data_d  = {frame_cnt_q, err_q};
          tx_valid_d = 1'b1;
          hdr_d      = 1'b1;
          state_d    = SEND;
`else
          state_d    = FETCH;
`endif
        end else if (tmo_expire) begin
          tmo_clr              = 1'b1;
          err_set[ERR_TIMEOUT] = 1'b1;
          state_d              = IDLE;
        end
      end
      FETCH: begin
        // First cycle presents the address, second captures the RAM output.
        if (!fetch_wait_q) begin
          fetch_wait_d = 1'b1;
        end else begin
          tx_data_d  = res_rd_data;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_sent) begin
          tx_valid_d = 1'b0;
`ifdef CS_SEQ_HDR_EN
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = FETCH;
          end else
`endif
          if (out_cnt_q == OUT_LAST) begin
            out_cnt_d = '0;
            state_d   = DONE;
          end else begin
            out_cnt_d = out_cnt_q + OAW'(1);
            state_d   = FETCH;
          end
        end
      end
      DONE: begin
`ifdef CS_SEQ_HDR_EN
        frame_cnt_d = frame_cnt_q + 5'd1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rx_valid && (state_q inside {START, COMPUTE, FETCH, SEND, DONE}))
      err_set[ERR_OVERRUN] = 1'b1;

    err_d = (err_clr ? '0 : err_q) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      fetch_wait_q  <= 1'b0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_addr_q <= '0;
      buf_wr_data_q <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      fetch_wait_q  <= fetch_wait_d;
      buf_wr_en_q   <= buf_wr_en_d;
      buf_wr_addr_q <= buf_wr_addr_d;
      buf_wr_data_q <= buf_wr_data_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      err_q         <= err_d;
    end
  end

`ifdef CS_SEQ_HDR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      hdr_q       <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      hdr_q       <= hdr_d;
    end
  end
`endif

  assign buf_wr_en   = buf_wr_en_q;
  assign buf_wr_addr = buf_wr_addr_q;
  assign buf_wr_data = buf_wr_data_q;
  assign eng_start   = (state_q == START);
  assign res_rd_addr = out_cnt_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign frame_done  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign err_flags   = err_q;

endmodule

// File: tb/tb_cs_frame_sequencer.sv
// Scoreboard bench for cs_frame_sequencer: a default instance for frame traffic
// and a TIMEOUT_CYC=16 instance for the compute-timeout boundaries.
module tb_cs_frame_sequencer;

  localparam int N_IN  = 64;
  localparam int M_OUT = 16;
  localparam int IAW   = 6;
  localparam int OAW   = 4;

  logic           clk, rst_n;
  logic           ssel_n, rx_valid, eng_done, tx_sent, err_clr;
  logic [7:0]     rx_data, res_rd_data;
  logic           buf_wr_en, eng_start, tx_valid, frame_done, busy;
  logic [IAW-1:0] buf_wr_addr;
  logic [7:0]     buf_wr_data, tx_data;
  logic [OAW-1:0] res_rd_addr;
  logic [2:0]     err_flags;

  logic           t_ssel_n, t_rx_valid, t_eng_done, t_tx_sent;
  logic [7:0]     t_rx_data;
  logic           t_buf_wr_en, t_eng_start, t_tx_valid, t_frame_done, t_busy;
  logic [IAW-1:0] t_buf_wr_addr;
  logic [7:0]     t_buf_wr_data, t_tx_data;
  logic [OAW-1:0] t_res_rd_addr;
  logic [2:0]     t_err_flags;

  logic [7:0]     res_ram [M_OUT];
  logic [IAW+7:0] wr_q [$];
  logic [7:0]     tx_q [$];
  logic [2:0]     exp_err;
`ifdef CS_SEQ_HDR_EN
  logic [4:0]     hdr_frames;
`endif

  int n_checks, n_errors;
  int es_cnt, fd_cnt, t_es_cnt, t_fd_cnt, t_tx_cnt;

  cs_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ssel_n(ssel_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .eng_start(eng_start), .eng_done(eng_done), .res_rd_addr(res_rd_addr),
    .res_rd_data(res_rd_data), .tx_valid(tx_valid), .tx_data(tx_data), .tx_sent(tx_sent),
    .frame_done(frame_done), .busy(busy), .err_flags(err_flags), .err_clr(err_clr)
  );

  cs_frame_sequencer #(.TIMEOUT_CYC(16)) dut_t (
    .clk(clk), .rst_n(rst_n), .ssel_n(t_ssel_n), .rx_valid(t_rx_valid), .rx_data(t_rx_data),
    .buf_wr_en(t_buf_wr_en), .buf_wr_addr(t_buf_wr_addr), .buf_wr_data(t_buf_wr_data),
    .eng_start(t_eng_start), .eng_done(t_eng_done), .res_rd_addr(t_res_rd_addr),
    .res_rd_data(8'h5A), .tx_valid(t_tx_valid), .tx_data(t_tx_data), .tx_sent(t_tx_sent),
    .frame_done(t_frame_done), .busy(t_busy), .err_flags(t_err_flags), .err_clr(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result RAM with one cycle of read latency, preloaded with 0xA0..0xAF.
  initial for (int i = 0; i < M_OUT; i++) res_ram[i] = 8'hA0 + 8'(i);
  always @(posedge clk) res_rd_data <= res_ram[res_rd_addr];

  // Buffer-write scoreboard and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_start)    es_cnt++;
      if (frame_done)   fd_cnt++;
      if (t_eng_start)  t_es_cnt++;
      if (t_frame_done) t_fd_cnt++;
      if (t_tx_valid)   t_tx_cnt++;
      if (buf_wr_en === 1'b1) begin
        n_checks++;
        if (wr_q.size() == 0) begin
          $display("[TB] FAIL buf_write_unexpected: got addr=%0d data=%02h, required no write",
                   buf_wr_addr, buf_wr_data);
          n_errors++;
        end else if ({buf_wr_addr, buf_wr_data} !== wr_q[0]) begin
          $display("[TB] FAIL buf_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   buf_wr_addr, buf_wr_data, wr_q[0][IAW+7:8], wr_q[0][7:0]);
          n_errors++;
          void'(wr_q.pop_front());
        end else begin
          void'(wr_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks %0d errors",
             n_checks, n_errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one host frame, models the engine and the SPI sender.
  task automatic drive_frame(input int sent_delay, input int n_overrun, input int abort_at);
    int es0, fd0, w, total;
    logic [7:0] exp_b, held;
    bit stable;
    es0 = es_cnt;
    fd0 = fd_cnt;
    ssel_n = 1'b0;
    tick();
    for (int i = 0; i < N_IN; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(i);
      wr_q.push_back({IAW'(i), 8'(i)});
      tick();
      rx_valid = 1'b0;
      tick();
    end
    ssel_n = 1'b1;
    for (int j = 0; j < n_overrun; j++) begin
      rx_valid = 1'b1;
      rx_data  = 8'hEE;
      tick();
      rx_valid = 1'b0;
      tick();
    end
    if (n_overrun > 0) exp_err[1] = 1'b1;
    repeat (19 - 2 * n_overrun) tick();
    eng_done = 1'b1;
`ifdef CS_SEQ_HDR_EN
    tx_q.push_back({hdr_frames, exp_err});
`endif
    for (int i = 0; i < M_OUT; i++) tx_q.push_back(8'hA0 + 8'(i));
    tick();
    eng_done = 1'b0;
    total = tx_q.size();
    for (int k = 0; k < total; k++) begin
      w = 0;
      while (tx_valid !== 1'b1 && w < 100) begin
        tick();
        w++;
      end
      n_checks++;
      if (tx_valid !== 1'b1) begin
        $display("[TB] FAIL tx_wait: byte %0d tx_valid=%b, required 1 within 100 cycles", k, tx_valid);
        n_errors++;
        tx_q.delete();
        return;
      end
      exp_b = tx_q.pop_front();
      n_checks++;
      if (tx_data !== exp_b) begin
        $display("[TB] FAIL tx_byte: byte %0d got %02h, required %02h", k, tx_data, exp_b);
        n_errors++;
      end
      held   = tx_data;
      stable = 1'b1;
      repeat (sent_delay) begin
        tick();
        if (tx_valid !== 1'b1 || tx_data !== held) stable = 1'b0;
      end
      if (sent_delay > 0) begin
        n_checks++;
        if (!stable) begin
          $display("[TB] FAIL tx_hold: byte %0d now valid=%b data=%02h, required valid=1 data=%02h",
                   k, tx_valid, tx_data, held);
          n_errors++;
        end
      end
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, tx_valid, tx_data, eng_start, frame_done, buf_wr_en, buf_wr_addr,
             buf_wr_data, res_rd_addr, err_flags} !== '0) begin
          $display("[TB] FAIL async_reset: busy=%b tx_valid=%b tx_data=%02h res_rd_addr=%0d err=%b, required all 0",
                   busy, tx_valid, tx_data, res_rd_addr, err_flags);
          n_errors++;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tx_q.delete();
        exp_err = 3'b000;
`ifdef CS_SEQ_HDR_EN
        hdr_frames = 5'd0;
`endif
        tick();
        return;
      end
      tx_sent = 1'b1;
      tick();
      tx_sent = 1'b0;
    end
    w = 0;
    while (fd_cnt == fd0 && w < 10) begin
      tick();
      w++;
    end
    tick();
    tick();
    n_checks++;
    if (fd_cnt - fd0 != 1) begin
      $display("[TB] FAIL frame_done_count: got %0d pulses, required 1", fd_cnt - fd0);
      n_errors++;
    end
    n_checks++;
    if (es_cnt - es0 != 1) begin
      $display("[TB] FAIL eng_start_count: got %0d pulses, required 1", es_cnt - es0);
      n_errors++;
    end
    n_checks++;
    if (busy !== 1'b0 || err_flags !== exp_err) begin
      $display("[TB] FAIL frame_end: busy=%b err=%b, required busy=0 err=%b", busy, err_flags, exp_err);
      n_errors++;
    end
    n_checks++;
    if (wr_q.size() != 0 || tx_q.size() != 0) begin
      $display("[TB] FAIL scoreboard_drain: %0d writes %0d tx bytes left, required 0 0",
               wr_q.size(), tx_q.size());
      n_errors++;
      wr_q.delete();
      tx_q.delete();
    end
`ifdef CS_SEQ_HDR_EN
    hdr_frames = hdr_frames + 5'd1;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, tx_valid, tx_data, eng_start, frame_done, buf_wr_en, buf_wr_addr,
         buf_wr_data, res_rd_addr, err_flags} !== '0) begin
      $display("[TB] FAIL reset_state: busy=%b tx_valid=%b err=%b wr_en=%b, required all 0",
               busy, tx_valid, err_flags, buf_wr_en);
      n_errors++;
    end
    rst_n = 1'b1;
    tick();
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || err_flags !== 3'b000) begin
      $display("[TB] FAIL idle_rx_ignored: busy=%b err=%b, required busy=0 err=000", busy, err_flags);
      n_errors++;
    end
  endtask

  task automatic test_full_frame();
    drive_frame(0, 0, -1);
  endtask

  task automatic test_back_to_back();
    drive_frame(3, 0, -1);
  endtask

  task automatic test_short_frame();
    int es0;
    es0 = es_cnt;
    ssel_n = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'h80 + 8'(i);
      wr_q.push_back({IAW'(i), 8'h80 + 8'(i)});
      tick();
      rx_valid = 1'b0;
      tick();
    end
    ssel_n  = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 3'b001;
    tick();
    n_checks++;
    if (err_flags !== exp_err || busy !== 1'b0 || es_cnt != es0 || wr_q.size() != 0) begin
      $display("[TB] FAIL short_frame: err=%b busy=%b starts=%0d pending_writes=%0d, required err=001 busy=0 starts=0 pending=0",
               err_flags, busy, es_cnt - es0, wr_q.size());
      n_errors++;
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 3'b000;
    n_checks++;
    if (err_flags !== exp_err) begin
      $display("[TB] FAIL err_clr: err=%b, required 000", err_flags);
      n_errors++;
    end
  endtask

  task automatic test_overrun();
    drive_frame(0, 3, -1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 3'b000;
    n_checks++;
    if (err_flags !== exp_err) begin
      $display("[TB] FAIL overrun_clr: err=%b, required 000", err_flags);
      n_errors++;
    end
  endtask

  task automatic test_backpressure_reset();
    drive_frame(50, 0, 4);
    drive_frame(0, 0, -1);
  endtask

  task automatic test_timeout();
    int n, fd0, es0, tx0, w, t_total;
    fd0 = t_fd_cnt;
    t_total = M_OUT;
`ifdef CS_SEQ_HDR_EN
    t_total = M_OUT + 1;
`endif
    t_ssel_n = 1'b0;
    tick();
    for (int i = 0; i < N_IN; i++) begin
      t_rx_valid = 1'b1;
      t_rx_data  = 8'(i);
      tick();
      t_rx_valid = 1'b0;
      tick();
    end
    t_ssel_n = 1'b1;
    repeat (15) tick();
    t_eng_done = 1'b1;
    tick();
    t_eng_done = 1'b0;
    n_checks++;
    if (t_err_flags !== 3'b000 || t_busy !== 1'b1) begin
      $display("[TB] FAIL done_wins_timeout: err=%b busy=%b, required err=000 busy=1", t_err_flags, t_busy);
      n_errors++;
    end
    for (int k = 0; k < t_total; k++) begin
      w = 0;
      while (t_tx_valid !== 1'b1 && w < 100) begin
        tick();
        w++;
      end
      if (t_tx_valid !== 1'b1) begin
        n_checks++;
        $display("[TB] FAIL t_tx_wait: byte %0d tx_valid=%b, required 1", k, t_tx_valid);
        n_errors++;
        break;
      end
      if (k == t_total - 1) begin
        n_checks++;
        if (t_tx_data !== 8'h5A) begin
          $display("[TB] FAIL t_tx_byte: got %02h, required 5a", t_tx_data);
          n_errors++;
        end
      end
      t_tx_sent = 1'b1;
      tick();
      t_tx_sent = 1'b0;
    end
    repeat (4) tick();
    n_checks++;
    if (t_fd_cnt - fd0 != 1 || t_busy !== 1'b0) begin
      $display("[TB] FAIL t_frame_end: frame_done=%0d busy=%b, required 1 and 0", t_fd_cnt - fd0, t_busy);
      n_errors++;
    end

    es0 = t_es_cnt;
    tx0 = t_tx_cnt;
    t_ssel_n = 1'b0;
    tick();
    for (int i = 0; i < N_IN; i++) begin
      t_rx_valid = 1'b1;
      t_rx_data  = 8'hFF - 8'(i);
      tick();
      t_rx_valid = 1'b0;
      tick();
    end
    t_ssel_n = 1'b1;
    n = 0;
    while (t_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    n_checks++;
    if (n != 16) begin
      $display("[TB] FAIL timeout_cycles: compute lasted %0d cycles, required 16", n);
      n_errors++;
    end
    n_checks++;
    if (t_err_flags !== 3'b100 || t_busy !== 1'b0) begin
      $display("[TB] FAIL timeout_flag: err=%b busy=%b, required err=100 busy=0", t_err_flags, t_busy);
      n_errors++;
    end
    n_checks++;
    if (t_es_cnt - es0 != 1 || t_tx_cnt != tx0) begin
      $display("[TB] FAIL timeout_outputs: starts=%0d tx_valid_cycles=%0d, required 1 and 0",
               t_es_cnt - es0, t_tx_cnt - tx0);
      n_errors++;
    end
  endtask

  initial begin
    n_checks = 0;   n_errors = 0;
    es_cnt   = 0;   fd_cnt   = 0;
    t_es_cnt = 0;   t_fd_cnt = 0;   t_tx_cnt = 0;
    exp_err  = 3'b000;
`ifdef CS_SEQ_HDR_EN
    hdr_frames = 5'd0;
`endif
    rst_n    = 1'b0;
    ssel_n   = 1'b1;  rx_valid   = 1'b0;  rx_data   = 8'h00;
    eng_done = 1'b0;  tx_sent    = 1'b0;  err_clr   = 1'b0;
    t_ssel_n = 1'b1;  t_rx_valid = 1'b0;  t_rx_data = 8'h00;
    t_eng_done = 1'b0; t_tx_sent = 1'b0;

    test_reset();
    test_full_frame();
    test_back_to_back();
    test_short_frame();
    test_overrun();
    test_backpressure_reset();
    test_timeout();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
